// File: rtl/fsm_seq_param_if.sv
// fsm_seq_param_if: control/status bundle for fsm_seq_param (widths follow NUM_STATES/ENCODING)
interface fsm_seq_param_if #(
  parameter int NUM_STATES = 3,
  parameter int ENCODING = 0
);
  localparam int IDXW = NUM_STATES > 2 ? $clog2(NUM_STATES) : 1;
  localparam int SW = ENCODING == 1 ? NUM_STATES : IDXW;
  logic en;
  logic dir;
  logic load;
  logic [IDXW-1:0] load_idx;
  logic [SW-1:0] state_vec;
  logic [IDXW-1:0] state_idx;
  logic q;
  logic wrap;
  logic err;
  modport master(output en, dir, load, load_idx, input state_vec, state_idx, q, wrap, err);
  modport slave(input en, dir, load, load_idx, output state_vec, state_idx, q, wrap, err);
endinterface

// File: rtl/fsm_seq_param.sv
// fsm_seq_param: N-state ring sequencer, binary/one-hot/Gray state register; FSM_DWELL_EN adds a per-state dwell counter
module fsm_seq_param #(
  parameter int NUM_STATES = 3,
  parameter int ENCODING = 0,
  parameter int OUT_STATE = 0,
  parameter int DWELL_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  fsm_seq_param_if.slave bus
);
  localparam int IDXW = NUM_STATES > 2 ? $clog2(NUM_STATES) : 1;
  localparam int SW = ENCODING == 1 ? NUM_STATES : IDXW;
  localparam logic [IDXW:0] NS = (IDXW + 1)'(NUM_STATES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_STATES - 1);
  logic [SW-1:0] sv, sv_n;
  logic [IDXW-1:0] idx, nxt;
  logic valid, load_ok, adv, step, wrap, wrap_n, err;
  function automatic logic [SW-1:0] enc(input logic [IDXW-1:0] i);
    return ENCODING == 1 ? SW'(1) << i : ENCODING == 2 ? SW'(i ^ (i >> 1)) : SW'(i);
  endfunction
  // Decode the register to an index; illegal codes read as index 0 and are flagged invalid
  generate
    if (ENCODING == 1) begin : g_onehot
      always_comb begin
        idx = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_STATES; i++)
          if (sv == SW'(1) << i) begin
            idx = IDXW'(i);
            valid = 1'b1;
          end
      end
    end else if (ENCODING == 2) begin : g_gray
      logic [IDXW-1:0] b;
      always_comb begin
        b = sv;
        for (int i = IDXW - 2; i >= 0; i--) b[i] = b[i+1] ^ sv[i];
        valid = {1'b0, b} < NS;
        idx = valid ? b : '0;
      end
    end else begin : g_bin
      always_comb begin
        valid = {1'b0, sv} < NS;
        idx = valid ? sv : '0;
      end
    end
  endgenerate
`ifdef FSM_DWELL_EN
  localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  logic [CW-1:0] cnt;
  assign step = cnt == CW'(DWELL_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset || bus.load || adv) cnt <= '0;
    else if (bus.en) cnt <= cnt + 1'b1;
`else
  assign step = DWELL_CYCLES > 0;
`endif
  always_comb begin
    load_ok = {1'b0, bus.load_idx} < NS;
    adv = bus.en & ~bus.load & step;
    nxt = bus.dir ? (idx == '0 ? LAST : idx - 1'b1) : (idx == LAST ? '0 : idx + 1'b1);
    sv_n = bus.load & load_ok ? enc(bus.load_idx) : adv ? enc(nxt) : valid ? sv : enc('0);
    wrap_n = adv & (bus.dir ? idx == '0 : idx == LAST);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sv <= enc('0);
      wrap <= 1'b0;
      err <= 1'b0;
    end else begin
      sv <= sv_n;
      wrap <= wrap_n;
      err <= err | (bus.load & ~load_ok);
    end
  end
  assign bus.state_vec = sv;
  assign bus.state_idx = idx;
  assign bus.q = idx == IDXW'(OUT_STATE);
  assign bus.wrap = wrap;
  assign bus.err = err;
endmodule

// File: tb/tb_fsm_seq_param.sv
// tb_fsm_seq_param: five differently configured sequencers checked every cycle against a modular-arithmetic model
module tb_fsm_seq_param;
  localparam int K = 5;
  localparam int NS [K] = '{3, 5, 6, 4, 3};
  localparam int ENC [K] = '{0, 1, 2, 0, 0};
  localparam int OUTS [K] = '{0, 2, 5, 0, 1};
  localparam int DWC [K] = '{1, 1, 1, 1, 3};
`ifdef FSM_DWELL_EN
  localparam bit DWELL = 1'b1;
  int t6[8] = '{0, 0, 1, 1, 1, 1, 1, 2};
`else
  localparam bit DWELL = 1'b0;
  int t6[8] = '{1, 2, 0, 1, 1, 1, 2, 0};
`endif
  int t6en[8] = '{1, 1, 1, 1, 0, 0, 1, 1};
  int t1[7] = '{1, 2, 0, 1, 2, 0, 1};
  int t2[6] = '{16, 8, 4, 2, 1, 16};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_en[K], s_dir[K], s_load[K];
  logic [7:0] s_lidx[K];
  logic [31:0] d_idx[K], d_vec[K];
  logic d_q[K], d_wrap[K], d_err[K];
  int m_idx[K], m_cnt[K];
  bit m_wrap[K], m_err[K];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  fsm_seq_param_if #(.NUM_STATES(3), .ENCODING(0)) b0();
  fsm_seq_param_if #(.NUM_STATES(5), .ENCODING(1)) b1();
  fsm_seq_param_if #(.NUM_STATES(6), .ENCODING(2)) b2();
  fsm_seq_param_if #(.NUM_STATES(4), .ENCODING(0)) b3();
  fsm_seq_param_if #(.NUM_STATES(3), .ENCODING(0)) b4();
  fsm_seq_param #(.NUM_STATES(3), .ENCODING(0), .OUT_STATE(0), .DWELL_CYCLES(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
  fsm_seq_param #(.NUM_STATES(5), .ENCODING(1), .OUT_STATE(2), .DWELL_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  fsm_seq_param #(.NUM_STATES(6), .ENCODING(2), .OUT_STATE(5), .DWELL_CYCLES(1)) u2 (.clk(clk), .reset(reset), .bus(b2));
  fsm_seq_param #(.NUM_STATES(4), .ENCODING(0), .OUT_STATE(0), .DWELL_CYCLES(1)) u3 (.clk(clk), .reset(reset), .bus(b3));
  fsm_seq_param #(.NUM_STATES(3), .ENCODING(0), .OUT_STATE(1), .DWELL_CYCLES(3)) u4 (.clk(clk), .reset(reset), .bus(b4));

  assign b0.en = s_en[0]; assign b0.dir = s_dir[0]; assign b0.load = s_load[0]; assign b0.load_idx = s_lidx[0][1:0];
  assign b1.en = s_en[1]; assign b1.dir = s_dir[1]; assign b1.load = s_load[1]; assign b1.load_idx = s_lidx[1][2:0];
  assign b2.en = s_en[2]; assign b2.dir = s_dir[2]; assign b2.load = s_load[2]; assign b2.load_idx = s_lidx[2][2:0];
  assign b3.en = s_en[3]; assign b3.dir = s_dir[3]; assign b3.load = s_load[3]; assign b3.load_idx = s_lidx[3][1:0];
  assign b4.en = s_en[4]; assign b4.dir = s_dir[4]; assign b4.load = s_load[4]; assign b4.load_idx = s_lidx[4][1:0];
  assign d_idx[0] = 32'(b0.state_idx); assign d_vec[0] = 32'(b0.state_vec);
  assign d_idx[1] = 32'(b1.state_idx); assign d_vec[1] = 32'(b1.state_vec);
  assign d_idx[2] = 32'(b2.state_idx); assign d_vec[2] = 32'(b2.state_vec);
  assign d_idx[3] = 32'(b3.state_idx); assign d_vec[3] = 32'(b3.state_vec);
  assign d_idx[4] = 32'(b4.state_idx); assign d_vec[4] = 32'(b4.state_vec);
  assign d_q[0] = b0.q; assign d_wrap[0] = b0.wrap; assign d_err[0] = b0.err;
  assign d_q[1] = b1.q; assign d_wrap[1] = b1.wrap; assign d_err[1] = b1.err;
  assign d_q[2] = b2.q; assign d_wrap[2] = b2.wrap; assign d_err[2] = b2.err;
  assign d_q[3] = b3.q; assign d_wrap[3] = b3.wrap; assign d_err[3] = b3.err;
  assign d_q[4] = b4.q; assign d_wrap[4] = b4.wrap; assign d_err[4] = b4.err;

  function automatic int vec_of(input int enc, input int i);
    return enc == 1 ? 1 << i : enc == 2 ? i ^ (i >> 1) : i;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  // Reference model: ring position as an integer advanced modulo N
  always @(posedge clk)
    for (int k = 0; k < K; k++)
      if (reset) begin
        m_idx[k] <= 0; m_cnt[k] <= 0; m_wrap[k] <= 1'b0; m_err[k] <= 1'b0;
      end else if (s_load[k]) begin
        m_wrap[k] <= 1'b0; m_cnt[k] <= 0;
        if (int'(s_lidx[k]) < NS[k]) m_idx[k] <= int'(s_lidx[k]);
        else m_err[k] <= 1'b1;
      end else if (s_en[k] && (!DWELL || m_cnt[k] == DWC[k] - 1)) begin
        m_cnt[k] <= 0;
        m_idx[k] <= (m_idx[k] + (s_dir[k] ? NS[k] - 1 : 1)) % NS[k];
        m_wrap[k] <= s_dir[k] ? m_idx[k] == 0 : m_idx[k] == NS[k] - 1;
      end else begin
        m_wrap[k] <= 1'b0;
        if (s_en[k]) m_cnt[k] <= m_cnt[k] + 1;
      end

  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < K; k++) begin
      chk("idx", k, d_idx[k], m_idx[k]);
      chk("vec", k, d_vec[k], vec_of(ENC[k], m_idx[k]));
      chk("q", k, 32'(d_q[k]), 32'(m_idx[k] == OUTS[k]));
      chk("wrap", k, 32'(d_wrap[k]), 32'(m_wrap[k]));
      chk("err", k, 32'(d_err[k]), 32'(m_err[k]));
    end
  end

  initial begin
    for (int k = 0; k < K; k++) begin
      s_en[k] = 1'b0; s_dir[k] = 1'b0; s_load[k] = 1'b0; s_lidx[k] = 8'd0;
    end
    repeat (2) @(negedge clk);
    chk("rst_vec_onehot", 1, d_vec[1], 32'd1);
    chk("rst_q_out0", 0, 32'(d_q[0]), 32'd1);
    chk("rst_q_out5", 2, 32'(d_q[2]), 32'd0);
    chk("rst_err", 2, 32'(d_err[2]), 32'd0);
    reset = 1'b0;
    s_en[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("t1_idx", 0, d_idx[0], t1[c]);
      chk("t1_wrap", 0, 32'(d_wrap[0]), 32'(t1[c] == 0));
      chk("t1_q", 0, 32'(d_q[0]), 32'(t1[c] == 0));
    end
    s_en[0] = 1'b0;
    s_en[1] = 1'b1; s_dir[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t2_vec", 1, d_vec[1], t2[c]);
      chk("t2_wrap", 1, 32'(d_wrap[1]), 32'(c == 0 || c == 5));
    end
    s_en[1] = 1'b0; s_dir[1] = 1'b0;
    s_load[2] = 1'b1; s_lidx[2] = 8'd4;
    @(negedge clk);
    chk("t3_load_vec", 2, d_vec[2], 32'd6);
    chk("t3_load_err", 2, 32'(d_err[2]), 32'd0);
    s_lidx[2] = 8'd7;
    @(negedge clk);
    chk("t3_bad_vec", 2, d_vec[2], 32'd6);
    chk("t3_bad_err", 2, 32'(d_err[2]), 32'd1);
    chk("t3_bad_wrap", 2, 32'(d_wrap[2]), 32'd0);
    s_load[2] = 1'b0; s_en[2] = 1'b1;
    @(negedge clk);
    chk("t3_adv_vec", 2, d_vec[2], 32'd7);
    chk("t3_adv_q", 2, 32'(d_q[2]), 32'd1);
    @(negedge clk);
    chk("t3_wrap_vec", 2, d_vec[2], 32'd0);
    chk("t3_wrap", 2, 32'(d_wrap[2]), 32'd1);
    s_en[2] = 1'b0;
    @(negedge clk);
    chk("t3_err_sticky", 2, 32'(d_err[2]), 32'd1);
    chk("t3_wrap_clear", 2, 32'(d_wrap[2]), 32'd0);
    s_en[3] = 1'b1; s_load[3] = 1'b1; s_lidx[3] = 8'd2;
    @(negedge clk);
    chk("t4_load_over_en", 3, d_idx[3], 32'd2);
    s_lidx[3] = 8'd3; reset = 1'b1;
    @(negedge clk);
    chk("t5_idx", 3, d_idx[3], 32'd0);
    chk("t5_q", 3, 32'(d_q[3]), 32'd1);
    chk("t5_wrap", 3, 32'(d_wrap[3]), 32'd0);
    chk("t5_err_cleared", 2, 32'(d_err[2]), 32'd0);
    reset = 1'b0; s_en[3] = 1'b0; s_load[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      s_en[4] = t6en[c] != 0;
      @(negedge clk);
      chk("t6_idx", 4, d_idx[4], t6[c]);
    end
    s_en[4] = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
